// File: rtl/rob_commit_if.sv
// rtl/rob_commit_if.sv - decode allocation, CDB, operand lookup and retire bundle for the ROB
interface rob_commit_if #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int OP_W   = 4
);
    logic              alloc_valid;
    logic [OP_W-1:0]   alloc_opcode;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [OP_W-1:0]   commit_opcode;
    logic [REG_W-1:0]  commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic              flush;
    logic [TAG_W:0]    count;

    modport master (
        output alloc_valid, alloc_opcode, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag, flush,
        input  alloc_ready, alloc_tag, rd_ready, rd_data, commit_valid, commit_tag,
               commit_opcode, commit_dest, commit_data, count
    );

    modport slave (
        input  alloc_valid, alloc_opcode, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag, flush,
        output alloc_ready, alloc_tag, rd_ready, rd_data, commit_valid, commit_tag,
               commit_opcode, commit_dest, commit_data, count
    );
endinterface

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer with tag-addressed completion and in-order retirement
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int OP_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    rob_commit_if.slave rob
);
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  ready;
    logic [OP_W-1:0]   ent_opcode [DEPTH];
    logic [REG_W-1:0]  ent_dest   [DEPTH];
    logic [DATA_W-1:0] ent_data   [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;
    logic              not_full;
    logic              do_alloc;
    logic              do_commit;
    logic              do_cdb;

    // Full check uses registered count only: a retiring entry does not free space this edge.
    assign not_full  = (count != FULL_COUNT);
    assign do_alloc  = rob.alloc_valid && not_full;
    assign do_commit = busy[head] && ready[head];
    assign do_cdb    = rob.cdb_valid && busy[rob.cdb_tag];

    assign rob.alloc_ready = not_full;
    assign rob.alloc_tag   = tail;
    assign rob.count       = count;
    assign rob.rd_ready    = busy[rob.rd_tag] && ready[rob.rd_tag];
    assign rob.rd_data     = busy[rob.rd_tag] ? ent_data[rob.rd_tag] : '0;

    always_ff @(posedge clk) begin
        if (rst || rob.flush) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            busy              <= '0;
            ready             <= '0;
            rob.commit_valid  <= 1'b0;
            rob.commit_tag    <= '0;
            rob.commit_opcode <= '0;
            rob.commit_dest   <= '0;
            rob.commit_data   <= '0;
        end else begin
            // A busy tag can never equal tail while allocating, so CDB and alloc never collide.
            if (do_cdb) begin
                ready[rob.cdb_tag]    <= 1'b1;
                ent_data[rob.cdb_tag] <= rob.cdb_data;
            end
            if (do_alloc) begin
                busy[tail]       <= 1'b1;
                ready[tail]      <= 1'b0;
                ent_opcode[tail] <= rob.alloc_opcode;
                ent_dest[tail]   <= rob.alloc_dest;
                tail             <= tail + 1'b1;
            end
            rob.commit_valid <= do_commit;
            if (do_commit) begin
                rob.commit_tag    <= head;
                rob.commit_opcode <= ent_opcode[head];
                rob.commit_dest   <= ent_dest[head];
                rob.commit_data   <= ent_data[head];
                busy[head]        <= 1'b0;
                ready[head]       <= 1'b0;
                head              <= head + 1'b1;
            end
            case ({do_alloc, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
